countdown_timer: RTL and testbench
==================================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter RELOAD, default 0, meaning: 1 = on expiry reload the last loaded value and keep running.
REQ-002 CLK  input  1  single clock for the block; all state changes on rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 DEC  input  1  count-enable tick; one decrement per high cycle.
REQ-005 Load  input  1  load D3..D0 into the count and reload register.
REQ-006 Start  input  1  begin or resume counting.
REQ-007 Stop  input  1  pause counting.
REQ-008 D3, D2, D1, D0  input  4 each  load digits: tenths, seconds units, seconds tens, minutes.
REQ-009 Q3, Q2, Q1, Q0  output  4 each  current count in BCD, same digit order as D3..D0.
REQ-010 Running  output  1  high while state is RUN.
REQ-011 Done  output  1  one-cycle expiry pulse.
REQ-012 Expired  output  1  high while state is DONE.

Function
REQ-013 The digit moduli SHALL be 10 for Q3, 10 for Q2, 6 for Q1 and 10 for Q0, so the maximum count is 9:59.9.
REQ-014 The FSM SHALL have four states: IDLE, RUN, PAUSED and DONE.
REQ-015 Load SHALL be accepted in IDLE, PAUSED and DONE, and ignored in RUN.
REQ-016 An accepted Load SHALL write the count and the reload register on the next edge.
REQ-017 An accepted Load SHALL move PAUSED or DONE to IDLE.
REQ-018 A load digit above its maximum SHALL be clamped: D3, D2 or D0 > 9 stores 9; D1 > 5 stores 5.
REQ-019 In IDLE, Start with a nonzero count SHALL go to RUN; with a zero count the block SHALL stay in IDLE.
REQ-020 In PAUSED, Start SHALL go to RUN.
REQ-021 In RUN, Stop SHALL go to PAUSED; in other states Stop has no effect.
REQ-022 Stop and Start in the same cycle: Stop wins.
REQ-023 Load and Start in the same cycle in IDLE: Load is applied and Start is ignored.
REQ-024 DEC SHALL be ignored outside RUN.
REQ-025 DEC and Stop in the same RUN cycle: no decrement; go to PAUSED.
REQ-026 The decrement SHALL be a borrow chain with one-edge latency:
- Q3 decrements; at 0 it becomes 9 and borrows from Q2.
- Q2 at 0 becomes 9 and borrows from Q1.
- Q1 at 0 becomes 5 and borrows from Q0.
- Q0 decrements; it is never below 0 while in RUN.
REQ-027 Terminal decrement (count 0:00.1 with DEC in RUN), RELOAD=0: the count becomes 0:00.0, the state goes to DONE, and Done is high for exactly the first cycle showing 0:00.0.
REQ-028 Terminal decrement, RELOAD=1: the count takes the reload-register value instead of 0:00.0, the state stays RUN, and Done pulses for one cycle.
REQ-029 RELOAD=1 with a reload register of 0:00.1 SHALL reload 0:00.1 on every terminal decrement.
REQ-030 In DONE the count SHALL hold 0:00.0; DEC, Start and Stop have no effect; only Load or Reset leave DONE.
REQ-031 Running, Expired and Done SHALL be registered outputs with no combinational path from inputs.
REQ-032 Q3..Q0 SHALL never hold a non-BCD or out-of-modulus value.

Reset
REQ-033 While Reset is high, independent of CLK:
- Q3..Q0 = 0 and the reload register = 0.
- State = IDLE.
- Running = 0, Done = 0, Expired = 0.
REQ-034 Reset asserted mid-RUN SHALL take effect immediately without waiting for a clock edge.
REQ-035 On release of Reset, the first edge SHALL process inputs normally.

Verification
REQ-036 Basic decrement: Load D0..D3 = 1,2,3,4; Start; one DEC -> Q0..Q3 = 1,2,3,3; Running = 1.
REQ-037 Full borrow chain: Load 1:00.0; Start; one DEC -> Q0..Q3 = 0,5,9,9.
REQ-038 Expiry with RELOAD=0: Load 0:00.2; Start; two DEC -> count 0:00.0, Done high exactly one cycle, Expired = 1; further DEC and Start leave the count at 0:00.0.
REQ-039 Expiry with RELOAD=1: Load 0:00.2; Start; two DEC -> count 0:00.2, Done pulses once, Running stays 1.
REQ-040 Pause and resume: in RUN at 0:05.0 assert Stop together with DEC -> count stays 0:05.0, state PAUSED; three DEC -> no change; Start then DEC -> 0:04.9.
REQ-041 Clamping and zero start: Load D1 = 7, D0 = 12 -> Q1 = 5, Q0 = 9; Load all zeros then Start -> state stays IDLE, Running = 0.
REQ-042 Async reset: assert Reset between clock edges mid-RUN -> all outputs 0 before the next edge.

Source files
------------

// File: rtl/countdown_timer.sv
// BCD countdown timer (M:SS.t) with IDLE/RUN/PAUSED/DONE control FSM.
// Optional auto-reload of the last loaded value on expiry.
module countdown_timer #(
  parameter logic RELOAD = 1'b0
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       DEC,
  input  logic       Load,
  input  logic       Start,
  input  logic       Stop,
  input  logic [3:0] D3,
  input  logic [3:0] D2,
  input  logic [3:0] D1,
  input  logic [3:0] D0,
  output logic [3:0] Q3,
  output logic [3:0] Q2,
  output logic [3:0] Q1,
  output logic [3:0] Q0,
  output logic       Running,
  output logic       Done,
  output logic       Expired
);

  localparam int unsigned DW = 4;

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] q3_q, q2_q, q1_q, q0_q;
  logic [DW-1:0] q3_d, q2_d, q1_d, q0_d;
  logic [DW-1:0] r3_q, r2_q, r1_q, r0_q;
  logic [DW-1:0] r3_d, r2_d, r1_d, r0_d;
  logic          running_q, running_d;
  logic          done_q, done_d;
  logic          expired_q, expired_d;
  logic          load_en;
  logic          count_zero;
  logic          terminal;

  function automatic logic [DW-1:0] clamp(input logic [DW-1:0] d, input logic [DW-1:0] mx);
    return (d > mx) ? mx : d;
  endfunction

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      q3_q      <= '0;
      q2_q      <= '0;
      q1_q      <= '0;
      q0_q      <= '0;
      r3_q      <= '0;
      r2_q      <= '0;
      r1_q      <= '0;
      r0_q      <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      q3_q      <= q3_d;
      q2_q      <= q2_d;
      q1_q      <= q1_d;
      q0_q      <= q0_d;
      r3_q      <= r3_d;
      r2_q      <= r2_d;
      r1_q      <= r1_d;
      r0_q      <= r0_d;
      running_q <= running_d;
      done_q    <= done_d;
      expired_q <= expired_d;
    end
  end

  // Next-state, count and flag logic
  always_comb begin
    state_d    = state_q;
    q3_d       = q3_q;
    q2_d       = q2_q;
    q1_d       = q1_q;
    q0_d       = q0_q;
    r3_d       = r3_q;
    r2_d       = r2_q;
    r1_d       = r1_q;
    r0_d       = r0_q;
    done_d     = 1'b0;
    load_en    = 1'b0;
    count_zero = (q3_q == '0) && (q2_q == '0) && (q1_q == '0) && (q0_q == '0);
    // A zero count is folded in so RUN can never underflow
    terminal   = (q3_q <= DW'(1)) && (q2_q == '0) && (q1_q == '0) && (q0_q == '0);

    case (state_q)
      IDLE: begin
        if (Load) begin
          load_en = 1'b1;
        end else if (Start && !count_zero) begin
          state_d = RUN;
        end
      end
      PAUSED: begin
        if (Load) begin
          load_en = 1'b1;
          state_d = IDLE;
        end else if (Start && !Stop) begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (Load) begin
          load_en = 1'b1;
          state_d = IDLE;
        end
      end
      RUN: begin
        if (Stop) begin
          state_d = PAUSED;
        end else if (DEC) begin
          if (terminal) begin
            done_d = 1'b1;
            if (RELOAD) begin
              q3_d = r3_q;
              q2_d = r2_q;
              q1_d = r1_q;
              q0_d = r0_q;
            end else begin
              q3_d    = '0;
              q2_d    = '0;
              q1_d    = '0;
              q0_d    = '0;
              state_d = DONE;
            end
          end else if (q3_q != '0) begin
            q3_d = q3_q - DW'(1);
          end else begin
            q3_d = DW'(9);
            if (q2_q != '0) begin
              q2_d = q2_q - DW'(1);
            end else begin
              q2_d = DW'(9);
              if (q1_q != '0) begin
                q1_d = q1_q - DW'(1);
              end else begin
                q1_d = DW'(5);
                q0_d = q0_q - DW'(1);
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_en) begin
      q3_d = clamp(D3, DW'(9));
      q2_d = clamp(D2, DW'(9));
      q1_d = clamp(D1, DW'(5));
      q0_d = clamp(D0, DW'(9));
      r3_d = q3_d;
      r2_d = q2_d;
      r1_d = q1_d;
      r0_d = q0_d;
    end

    running_d = (state_d == RUN);
    expired_d = (state_d == DONE);
  end

  assign Q3      = q3_q;
  assign Q2      = q2_q;
  assign Q1      = q1_q;
  assign Q0      = q0_q;
  assign Running = running_q;
  assign Done    = done_q;
  assign Expired = expired_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: instance 0 without reload, instance 1 with reload.
// Expected words are {Q0,Q1,Q2,Q3,Running,Done,Expired}; count shown as M S S t in hex.
module tb_countdown_timer;

  logic       clk;
  logic       rst;
  logic       dec_i   [2];
  logic       load_i  [2];
  logic       start_i [2];
  logic       stop_i  [2];
  logic [3:0] d3_i    [2];
  logic [3:0] d2_i    [2];
  logic [3:0] d1_i    [2];
  logic [3:0] d0_i    [2];
  logic [3:0] q3_o    [2];
  logic [3:0] q2_o    [2];
  logic [3:0] q1_o    [2];
  logic [3:0] q0_o    [2];
  logic       running_o [2];
  logic       done_o    [2];
  logic       expired_o [2];

  bit          q_inst [$];
  string       q_name [$];
  logic [18:0] q_exp  [$];

  int n_checks = 0;
  int n_fail   = 0;

  countdown_timer #(.RELOAD(1'b0)) u_dut0 (
    .CLK(clk), .Reset(rst), .DEC(dec_i[0]), .Load(load_i[0]), .Start(start_i[0]), .Stop(stop_i[0]),
    .D3(d3_i[0]), .D2(d2_i[0]), .D1(d1_i[0]), .D0(d0_i[0]),
    .Q3(q3_o[0]), .Q2(q2_o[0]), .Q1(q1_o[0]), .Q0(q0_o[0]),
    .Running(running_o[0]), .Done(done_o[0]), .Expired(expired_o[0])
  );

  countdown_timer #(.RELOAD(1'b1)) u_dut1 (
    .CLK(clk), .Reset(rst), .DEC(dec_i[1]), .Load(load_i[1]), .Start(start_i[1]), .Stop(stop_i[1]),
    .D3(d3_i[1]), .D2(d2_i[1]), .D1(d1_i[1]), .D0(d0_i[1]),
    .Q3(q3_o[1]), .Q2(q2_o[1]), .Q1(q1_o[1]), .Q0(q0_o[1]),
    .Running(running_o[1]), .Done(done_o[1]), .Expired(expired_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Queue an expected output word for the monitor
  task automatic chk(input bit i, input string nm, input logic [15:0] cnt,
                     input logic r, input logic dn, input logic ex);
    q_inst.push_back(i);
    q_name.push_back(nm);
    q_exp.push_back({cnt, r, dn, ex});
  endtask

  // One clock cycle of stimulus on instance i; d is {D0,D1,D2,D3}
  task automatic drive(input bit i, input logic de, input logic lo, input logic st,
                       input logic sp, input logic [15:0] d);
    @(negedge clk);
    dec_i[i]   = de;
    load_i[i]  = lo;
    start_i[i] = st;
    stop_i[i]  = sp;
    d0_i[i]    = d[15:12];
    d1_i[i]    = d[11:8];
    d2_i[i]    = d[7:4];
    d3_i[i]    = d[3:0];
    @(posedge clk);
    #1;
    dec_i[i]   = 1'b0;
    load_i[i]  = 1'b0;
    start_i[i] = 1'b0;
    stop_i[i]  = 1'b0;
  endtask

  // Monitor: compare every queued expectation on the falling edge
  initial begin
    bit          m_inst;
    string       m_name;
    logic [18:0] m_exp;
    logic [18:0] m_act;
    forever begin
      @(negedge clk);
      while (q_inst.size() != 0) begin
        m_inst = q_inst.pop_front();
        m_name = q_name.pop_front();
        m_exp  = q_exp.pop_front();
        m_act  = {q0_o[m_inst], q1_o[m_inst], q2_o[m_inst], q3_o[m_inst],
                  running_o[m_inst], done_o[m_inst], expired_o[m_inst]};
        n_checks++;
        if (m_act !== m_exp) begin
          n_fail++;
          $display("FAIL %s inst%0d: got cnt=%h run=%b done=%b exp=%b, required cnt=%h run=%b done=%b exp=%b",
                   m_name, m_inst, m_act[18:3], m_act[2], m_act[1], m_act[0],
                   m_exp[18:3], m_exp[2], m_exp[1], m_exp[0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      dec_i[i] = 1'b0; load_i[i] = 1'b0; start_i[i] = 1'b0; stop_i[i] = 1'b0;
      d0_i[i] = '0; d1_i[i] = '0; d2_i[i] = '0; d3_i[i] = '0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk(0, "reset0", 16'h0000, 0, 0, 0);
    chk(1, "reset1", 16'h0000, 0, 0, 0);
    @(negedge clk);
    #1 rst = 1'b0;

    // Basic load, start, decrement: 1:23.4 -> 1:23.3
    drive(0, 0, 1, 0, 0, 16'h1234); chk(0, "load_1234", 16'h1234, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 16'h0000); chk(0, "start", 16'h1234, 1, 0, 0);
    drive(0, 1, 0, 0, 0, 16'h0000); chk(0, "basic_dec", 16'h1233, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 16'h0000); chk(0, "no_dec_hold", 16'h1233, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 16'h0000); chk(0, "stop", 16'h1233, 0, 0, 0);

    // Full borrow chain: 1:00.0 -> 0:59.9
    drive(0, 0, 1, 0, 0, 16'h1000); chk(0, "load_paused", 16'h1000, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 16'h0000); chk(0, "start2", 16'h1000, 1, 0, 0);
    drive(0, 1, 0, 0, 0, 16'h0000); chk(0, "borrow_chain", 16'h0599, 1, 0, 0);

    // Pause and resume at 0:05.0
    drive(0, 0, 0, 0, 1, 16'h0000); chk(0, "stop2", 16'h0599, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 16'h0050); chk(0, "load_0050", 16'h0050, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 16'h0000); chk(0, "start3", 16'h0050, 1, 0, 0);
    drive(0, 1, 0, 0, 1, 16'h0000); chk(0, "dec_with_stop", 16'h0050, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 0, 0, 0, 16'h0000); chk(0, "dec_paused", 16'h0050, 0, 0, 0);
    end
    drive(0, 0, 0, 1, 0, 16'h0000); chk(0, "resume", 16'h0050, 1, 0, 0);
    drive(0, 1, 0, 0, 0, 16'h0000); chk(0, "resume_dec", 16'h0049, 1, 0, 0);
    drive(0, 0, 1, 0, 0, 16'h9999); chk(0, "load_in_run", 16'h0049, 1, 0, 0);
    drive(0, 0, 0, 1, 1, 16'h0000); chk(0, "stop_beats_start", 16'h0049, 0, 0, 0);

    // Clamping and zero start
    drive(0, 0, 1, 0, 0, 16'hC7AF); chk(0, "clamp", 16'h9599, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 16'h0000); chk(0, "load_zero", 16'h0000, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 16'h0000); chk(0, "zero_start", 16'h0000, 0, 0, 0);

    // Expiry without reload
    drive(0, 0, 1, 1, 0, 16'h0002); chk(0, "load_beats_start", 16'h0002, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 16'h0000); chk(0, "start4", 16'h0002, 1, 0, 0);
    drive(0, 1, 0, 0, 0, 16'h0000); chk(0, "dec_to_1", 16'h0001, 1, 0, 0);
    drive(0, 1, 0, 0, 0, 16'h0000); chk(0, "expiry", 16'h0000, 0, 1, 1);
    drive(0, 1, 0, 1, 0, 16'h0000); chk(0, "done_hold", 16'h0000, 0, 0, 1);
    drive(0, 0, 0, 0, 1, 16'h0000); chk(0, "done_stop", 16'h0000, 0, 0, 1);
    drive(0, 0, 1, 0, 0, 16'h0003); chk(0, "load_done", 16'h0003, 0, 0, 0);

    // Expiry with reload
    drive(1, 0, 1, 0, 0, 16'h0002); chk(1, "r_load", 16'h0002, 0, 0, 0);
    drive(1, 0, 0, 1, 0, 16'h0000); chk(1, "r_start", 16'h0002, 1, 0, 0);
    drive(1, 1, 0, 0, 0, 16'h0000); chk(1, "r_dec", 16'h0001, 1, 0, 0);
    drive(1, 1, 0, 0, 0, 16'h0000); chk(1, "r_reload", 16'h0002, 1, 1, 0);
    drive(1, 0, 0, 0, 0, 16'h0000); chk(1, "r_pulse_end", 16'h0002, 1, 0, 0);
    drive(1, 1, 0, 0, 0, 16'h0000); chk(1, "r_dec2", 16'h0001, 1, 0, 0);
    drive(1, 1, 0, 0, 0, 16'h0000); chk(1, "r_reload2", 16'h0002, 1, 1, 0);
    drive(1, 0, 0, 0, 1, 16'h0000); chk(1, "r_stop", 16'h0002, 0, 0, 0);
    drive(1, 0, 1, 0, 0, 16'h0001); chk(1, "r_load_01", 16'h0001, 0, 0, 0);
    drive(1, 0, 0, 1, 0, 16'h0000); chk(1, "r_start_01", 16'h0001, 1, 0, 0);
    drive(1, 1, 0, 0, 0, 16'h0000); chk(1, "r_reload_01a", 16'h0001, 1, 1, 0);
    drive(1, 1, 0, 0, 0, 16'h0000); chk(1, "r_reload_01b", 16'h0001, 1, 1, 0);

    // Asynchronous reset mid-RUN, observed before the next rising edge
    drive(0, 0, 0, 1, 0, 16'h0000); chk(0, "start5", 16'h0003, 1, 0, 0);
    drive(0, 1, 0, 0, 0, 16'h0000); chk(0, "dec_pre_rst", 16'h0002, 1, 0, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    chk(0, "async_rst0", 16'h0000, 0, 0, 0);
    chk(1, "async_rst1", 16'h0000, 0, 0, 0);
    @(negedge clk);
    #1 rst = 1'b0;
    drive(0, 0, 1, 0, 0, 16'h0010); chk(0, "post_rst_load", 16'h0010, 0, 0, 0);

    for (int k = 0; k < 10 && q_inst.size() != 0; k++) @(posedge clk);
    if (q_inst.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations unchecked, required 0", q_inst.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
